main_memory_responder: RTL

- Memory-side responder for the cache's miss path; the cache is the initiator.
- Serves single-word read (allocate) and write (writeback) requests against a 1024 x 20-bit backing array.
- Each request completes after a fixed programmable latency and is signalled by a one-cycle mem_ready pulse.
- Sits directly below the cache controller and models main memory for the cache subsystem.

---
 rtl/main_memory_responder.sv | 84 ++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Main-memory model serving the cache miss path. Each single-word read or write
// completes a fixed number of edges after acceptance and is flagged by a one-cycle mem_ready.
module main_memory_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 20,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ready,
  output logic              mem_busy
);

  // A latency of zero cannot be honoured, so it is clamped to one edge.
  localparam int EFF_LAT = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CNT_W   = (EFF_LAT > 1) ? $clog2(EFF_LAT) : 1;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_done;

  assign w_done   = (r_state == WAIT) && (r_cnt == '0);
  assign mem_busy = (r_state == WAIT);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      mem_ready    <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_rw    <= mem_rw;
            r_addr  <= mem_addr;
            r_data  <= mem_data_in;
            r_cnt   <= CNT_W'(EFF_LAT - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            mem_ready <= 1'b1;
            r_state   <= IDLE;
            if (!r_rw) mem_data_out <= r_mem[r_addr];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; clearing 2^ADDR_W words would defeat RAM
  // inference, and a reset-aborted write never reaches the completion edge.
  always_ff @(posedge clk) begin
    if (w_done && r_rw) r_mem[r_addr] <= r_data;
  end

endmodule
